// File: rtl/deinterleaver_4_4.sv
// deinterleaver_4_4: restores row order from a 4x4 column-interleaved symbol
// stream. Two 16-entry banks alternate: one fills from the channel side while
// the other drains through a registered valid/ready output stage.
module deinterleaver_4_4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             sof_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             sof_o,
   output logic             eof_o,
   input  logic             ready_i,
   output logic             err_o
);

   logic [WIDTH-1:0] bank [2][16];
   logic [1:0]       full;
   logic [1:0]       full_next;
   logic             wr_bank;
   logic [3:0]       wr_cnt;
   logic             rd_bank;
   logic [3:0]       rd_cnt;
   logic             in_hs;
   logic             resync;
   logic             wr_done;
   logic [3:0]       wr_addr;
   logic             load;
   logic             rd_done;
   logic [3:0]       rd_addr;

   // Handshake decode, write/read addressing and the next value of the bank-full flags
   always_comb begin
      ready_o   = !full[wr_bank] && !rst;
      in_hs     = valid_i && ready_o;
      resync    = in_hs && sof_i && (wr_cnt != 4'd0);
      wr_addr   = sof_i ? 4'd0 : wr_cnt;
      wr_done   = in_hs && !sof_i && (wr_cnt == 4'd15);
      load      = full[rd_bank] && (!valid_o || ready_i);
      rd_addr   = {rd_cnt[1:0], rd_cnt[3:2]};
      rd_done   = load && (rd_cnt == 4'd15);
      full_next = full;
      if (wr_done) begin
         full_next[wr_bank] = 1'b1;
      end
      if (rd_done) begin
         full_next[rd_bank] = 1'b0;
      end
   end

   // Symbol storage; contents are don't-care until a block has been written
   always_ff @(posedge clk) begin
      if (in_hs) begin
         bank[wr_bank][wr_addr] <= data_i;
      end
   end

   // Write pointer: a start-of-frame always restarts the current bank at index 0
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank <= 1'b0;
         wr_cnt  <= 4'd0;
         err_o   <= 1'b0;
      end else begin
         err_o <= resync;
         if (in_hs) begin
            if (sof_i) begin
               wr_cnt <= 4'd1;
            end else begin
               wr_cnt <= wr_cnt + 4'd1;
            end
            if (wr_done) begin
               wr_bank <= ~wr_bank;
            end
         end
      end
   end

   // Bank-full flags: set by a completed write, cleared once the last symbol is read out
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 2'b00;
      end else begin
         full <= full_next;
      end
   end

   // Output register: reads the bank in transposed order and holds under backpressure
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_bank <= 1'b0;
         rd_cnt  <= 4'd0;
         valid_o <= 1'b0;
         data_o  <= '0;
         sof_o   <= 1'b0;
         eof_o   <= 1'b0;
      end else if (load) begin
         data_o  <= bank[rd_bank][rd_addr];
         sof_o   <= (rd_cnt == 4'd0);
         eof_o   <= (rd_cnt == 4'd15);
         valid_o <= 1'b1;
         rd_cnt  <= rd_cnt + 4'd1;
         if (rd_done) begin
            rd_bank <= ~rd_bank;
         end
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_deinterleaver_4_4.sv
// tb_deinterleaver_4_4: directed stimulus with a matrix-transpose reference
// model and a per-cycle compare process on the output stream and err_o.
module tb_deinterleaver_4_4;

   localparam int WIDTH = 8;

   logic             clk     = 1'b0;
   logic             rst     = 1'b1;
   logic             valid_i = 1'b0;
   logic [WIDTH-1:0] data_i  = '0;
   logic             sof_i   = 1'b0;
   logic             ready_i = 1'b0;
   logic             ready_o;
   logic             valid_o;
   logic [WIDTH-1:0] data_o;
   logic             sof_o;
   logic             eof_o;
   logic             err_o;

   deinterleaver_4_4 #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_i),
      .data_i  (data_i),
      .sof_i   (sof_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .data_o  (data_o),
      .sof_o   (sof_o),
      .eof_o   (eof_o),
      .ready_i (ready_i),
      .err_o   (err_o)
   );

   // Free-running clock
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       sof;
      logic       eof;
   } sym_t;

   int   total = 0;
   int   bad   = 0;
   sym_t exp_q[$];
   sym_t exp_sym;
   sym_t push_sym;
   logic [7:0] grid [4][4];
   int   part_cnt      = 0;
   bit   err_pend      = 1'b0;
   bit   prev_hold     = 1'b0;
   logic [7:0] prev_data;
   logic prev_sof;
   logic prev_eof;
   int   cyc           = 0;
   int   in_count      = 0;
   int   out_count     = 0;
   int   ready_low     = 0;
   int   err_count     = 0;
   int   first_out_cyc = 0;
   int   last_out_cyc  = 0;
   bit   mark_first    = 1'b0;

   int   i0;
   int   o0;
   int   low0;
   int   e0;
   int   n;
   int   guard;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   // Symbol k of an interleaved block whose deinterleaved content is base..base+15
   function automatic logic [7:0] ilv(input int base, input int k);
      return 8'(base + (k % 4) * 4 + k / 4);
   endfunction

   task automatic applyStimulus(input logic [7:0] d, input logic s);
      int wait_cnt;
      wait_cnt = 0;
      valid_i = 1'b1;
      data_i  = d;
      sof_i   = s;
      @(negedge clk);
      while (!ready_o && wait_cnt < 200) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (wait_cnt >= 200) begin
         total++;
         bad++;
         $display("[TB] FAIL input_timeout: got ready_o=0 for %0d cycles, want 1", wait_cnt);
      end
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      sof_i   = 1'b0;
   endtask

   task automatic feedBlock(input int base);
      for (int k = 0; k < 16; k++) begin
         applyStimulus(ilv(base, k), k == 0);
      end
   endtask

   task automatic waitDrain(input string name);
      int wait_cnt;
      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 300) begin
         @(posedge clk);
         #1;
         wait_cnt++;
      end
      checkOutput(name, exp_q.size(), 0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference model and compare process: the input block is laid into a 4x4 grid
   // column by column and read back row by row
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         part_cnt  = 0;
         exp_q.delete();
         err_pend  = 1'b0;
         prev_hold = 1'b0;
      end else begin
         checkOutput("err_o", err_o, err_pend);
         if (err_o) err_count++;
         err_pend = 1'b0;
         if (!ready_o) ready_low++;
         if (prev_hold) begin
            checkOutput("hold_valid", valid_o, 1);
            checkOutput("hold_data", data_o, prev_data);
            checkOutput("hold_sof", sof_o, prev_sof);
            checkOutput("hold_eof", eof_o, prev_eof);
         end
         prev_hold = valid_o && !ready_i;
         prev_data = data_o;
         prev_sof  = sof_o;
         prev_eof  = eof_o;
         if (valid_o && ready_i) begin
            out_count++;
            if (mark_first) begin
               first_out_cyc = cyc;
               mark_first    = 1'b0;
            end
            last_out_cyc = cyc;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_output: got 0x%0h, want no output", data_o);
            end else begin
               exp_sym = exp_q.pop_front();
               checkOutput("out_data", data_o, exp_sym.data);
               checkOutput("out_sof", sof_o, exp_sym.sof);
               checkOutput("out_eof", eof_o, exp_sym.eof);
            end
         end
         if (valid_i && ready_o) begin
            in_count++;
            if (sof_i) begin
               if (part_cnt != 0) err_pend = 1'b1;
               part_cnt = 0;
            end
            grid[part_cnt % 4][part_cnt / 4] = data_i;
            part_cnt++;
            if (part_cnt == 16) begin
               for (int r = 0; r < 4; r++) begin
                  for (int c = 0; c < 4; c++) begin
                     push_sym.data = grid[r][c];
                     push_sym.sof  = (r == 0) && (c == 0);
                     push_sym.eof  = (r == 3) && (c == 3);
                     exp_q.push_back(push_sym);
                  end
               end
               part_cnt = 0;
            end
         end
      end
   end

   // Global time limit
   initial begin
      #200000;
      bad++;
      $display("[TB] FAIL watchdog: got no completion, want completion before time limit");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] time limit reached");
   end

   // Directed test sequence
   initial begin
      // reset held with valid_i high
      rst     = 1'b1;
      valid_i = 1'b1;
      data_i  = 8'h55;
      ready_i = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("rst_ready", ready_o, 0);
         checkOutput("rst_valid", valid_o, 0);
         checkOutput("rst_data", data_o, 0);
         checkOutput("rst_err", err_o, 0);
      end
      @(posedge clk);
      #1;
      rst     = 1'b0;
      valid_i = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_ready", ready_o, 1);
      checkOutput("post_rst_valid", valid_o, 0);
      @(posedge clk);
      #1;

      // single block with latency and literal order
      $display("[TB] single block");
      feedBlock(8'h00);
      @(negedge clk);
      checkOutput("lat_t1_valid", valid_o, 0);
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         checkOutput("single_valid", valid_o, 1);
         checkOutput("single_data", data_o, j);
         checkOutput("single_sof", sof_o, j == 0);
         checkOutput("single_eof", eof_o, j == 15);
      end
      @(negedge clk);
      checkOutput("single_end_valid", valid_o, 0);
      waitDrain("single_drain");

      // four back-to-back blocks
      $display("[TB] streaming");
      low0       = ready_low;
      o0         = out_count;
      mark_first = 1'b1;
      for (int b = 0; b < 4; b++) begin
         feedBlock(b * 16);
      end
      waitDrain("stream_drain");
      checkOutput("stream_count", out_count - o0, 64);
      checkOutput("stream_span", last_out_cyc - first_out_cyc, 63);
      checkOutput("stream_ready_low", ready_low - low0, 0);

      // backpressure with three blocks
      $display("[TB] backpressure");
      ready_i = 1'b0;
      i0      = in_count;
      o0      = out_count;
      fork
         begin
            for (int b = 0; b < 3; b++) begin
               feedBlock(b * 16);
            end
         end
         begin
            guard = 0;
            while (in_count - i0 < 32 && guard < 500) begin
               @(posedge clk);
               #1;
               guard++;
            end
            checkOutput("bp_accepted", in_count - i0, 32);
            @(negedge clk);
            checkOutput("bp_ready_low", ready_o, 0);
            checkOutput("bp_valid", valid_o, 1);
            checkOutput("bp_data", data_o, 8'h00);
            checkOutput("bp_sof", sof_o, 1);
            repeat (4) begin
               @(negedge clk);
               checkOutput("bp_ready_held", ready_o, 0);
               checkOutput("bp_data_held", data_o, 8'h00);
            end
            @(posedge clk);
            #1;
            ready_i = 1'b1;
            n     = 0;
            guard = 0;
            do begin
               @(negedge clk);
               if (valid_o && ready_i) n++;
               guard++;
            end while (!ready_o && guard < 100);
            checkOutput("bp_ready_back", ready_o, 1);
            checkOutput("bp_outputs_before_ready", n, 16);
         end
      join
      waitDrain("bp_drain");
      checkOutput("bp_count", out_count - o0, 48);

      // resync on the sixth symbol of a block
      $display("[TB] resync");
      e0 = err_count;
      o0 = out_count;
      applyStimulus(8'hE0, 1'b1);
      for (int k = 1; k < 5; k++) begin
         applyStimulus(8'(8'hE0 + k), 1'b0);
      end
      feedBlock(8'h40);
      waitDrain("resync_drain");
      checkOutput("resync_err_pulses", err_count - e0, 1);
      checkOutput("resync_count", out_count - o0, 16);

      // reset while block 0 drains and block 1 is full
      $display("[TB] reset mid-drain");
      ready_i = 1'b0;
      feedBlock(8'h00);
      feedBlock(8'h10);
      ready_i = 1'b1;
      guard   = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!(valid_o && data_o == 8'h06) && guard < 100);
      checkOutput("mid_reach_idx6", data_o, 8'h06);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid_idx7_data", data_o, 8'h07);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("mid_rst_valid", valid_o, 0);
      checkOutput("mid_rst_ready", ready_o, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("mid_post_ready", ready_o, 1);
      checkOutput("mid_post_valid", valid_o, 0);
      @(posedge clk);
      #1;
      o0 = out_count;
      feedBlock(8'h70);
      waitDrain("mid_fresh_drain");
      checkOutput("mid_fresh_count", out_count - o0, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/deinterleaver_4_4.md
# deinterleaver_4_4

Receive-side counterpart of `interleaver_4_4`. It takes the column-ordered 8-bit symbol stream produced by the 4x4 block interleaver and restores the original row order, one 16-symbol block at a time. Two 16-entry banks (ping-pong) let one block fill while the previous one drains, so sustained throughput is one symbol per cycle. The block sits between the channel-side symbol source and the downstream decoder, with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 8: symbol width in bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `valid_i` input 1: input symbol valid.
- `data_i` input WIDTH: input symbol, in interleaved order.
- `sof_i` input 1: marks the first symbol of an interleaved block; sampled only when `valid_i` is high.
- `ready_o` output 1: the block can accept an input symbol.
- `valid_o` output 1: output register holds a symbol.
- `data_o` output WIDTH: deinterleaved symbol.
- `sof_o` output 1: `data_o` is symbol 0 of a block.
- `eof_o` output 1: `data_o` is symbol 15 of a block.
- `ready_i` input 1: downstream accepts the symbol this cycle.
- `err_o` output 1: one-cycle pulse when a partial block is discarded.

## Operation
- An input handshake occurs when `valid_i & ready_o` is high. An output handshake occurs when `valid_o & ready_i` is high.
- Write side:
  - State is `wr_bank` (1 bit) and `wr_cnt` (4 bits).
  - Each input handshake stores `data_i` at `bank[wr_bank][wr_cnt]` and increments `wr_cnt`.
  - When `wr_cnt` wraps from 15 to 0, set `full[wr_bank]` and toggle `wr_bank`.
- Resync on `sof_i`:
  - If a handshake carries `sof_i=1` while `wr_cnt != 0`, the partial block is discarded.
  - The symbol is written at index 0 of the same bank, and `wr_cnt` becomes 1.
  - `err_o` is high in the following cycle.
  - `sof_i` with `wr_cnt == 0` is normal operation.
- Read side:
  - State is `rd_bank` (1 bit) and `rd_cnt` (4 bits).
  - Output symbol j of a block is read from `bank[rd_bank][{j[1:0], j[3:2]}]` (4x4 transpose, which is self-inverse). This restores the original order exactly.
- Output register (`data_o`, `sof_o`, `eof_o`, `valid_o`):
  - Loads when `full[rd_bank]` is set and (`!valid_o` or `ready_i`).
  - `sof_o` = (`rd_cnt == 0`); `eof_o` = (`rd_cnt == 15`).
  - On loading index 15: clear `full[rd_bank]`, toggle `rd_bank`, and set `rd_cnt` to 0.
  - If nothing loads and `ready_i` is high, `valid_o` falls.
- `ready_o = !full[wr_bank] & !rst`. This is combinational from registers; there is no path from `valid_i`.
- Simultaneous events:
  - A set of `full[x]` and a clear of `full[y]` in the same cycle is legal. The write and read banks are never the same bank with that bank both filling and draining.
  - When both banks are full, `ready_o` is 0.
  - `ready_o` returns to 1 in the cycle after the read side clears the bank that `wr_bank` points to.
- While `valid_o & !ready_i`, `data_o`, `sof_o` and `eof_o` are held stable.

## Timing
- Reset values:
  - `valid_o`, `sof_o`, `eof_o`, `err_o` = 0; `data_o` = 0.
  - `full` = 00; `wr_bank`, `rd_bank`, `wr_cnt`, `rd_cnt` = 0.
  - `ready_o` is 0 while `rst` is high and 1 in the first cycle after `rst` falls.
  - Bank contents are not reset.
- `rst` asserted mid-operation: all state returns to reset values on the next edge. In-flight blocks are dropped, and no output handshake follows.
- Latency: the last input handshake of a block occurs in cycle t. `full` is set at the end of t. The first output is loaded at the end of t+1, and `valid_o` with `sof_o` is high in cycle t+2.
- Throughput: with `ready_i=1` and continuous input, after the initial latency there is one output per cycle with no bubbles, including across block boundaries. `ready_o` never drops.
- `err_o` is high exactly one cycle, in the cycle after the offending handshake.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `valid_i`=1. Required response: `ready_o`=0, `valid_o`=0, `data_o`=0x00; one cycle after `rst` falls, `ready_o`=1.
- Single block:
  - Stimulus: feed 0x00,0x04,0x08,0x0C,0x01,0x05,…,0x0F with `sof_i` on the first symbol and `ready_i`=1.
  - Required response: `data_o` = 0x00..0x0F in order, `sof_o` with 0x00, `eof_o` with 0x0F, first `valid_o` 2 cycles after the last input handshake.
- Streaming: feed 4 back-to-back transposed blocks (base values 0x00, 0x10, 0x20, 0x30). Required response: 64 consecutive outputs 0x00..0x3F with no gaps after the first, and `ready_o` constantly 1.
- Backpressure: hold `ready_i`=0 and feed 3 blocks. Required response:
  - `ready_o` falls after the 32nd accepted symbol, and `data_o`=0x00 is held stable.
  - After releasing `ready_i`, outputs resume in order, and `ready_o` returns after 16 outputs.
- Resync: assert `sof_i` on the 6th symbol of a block, then send a full valid block. Required response: one `err_o` pulse, the partial block is never output, and the following block is output correctly.
- Reset mid-drain: assert `rst` at output index 7 of block 0 while block 1 is full. Required response: next cycle `valid_o`=0 and `ready_o`=0; after reset a fresh block is output correctly with `sof_o`.
